// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types, defaults and width helpers for the tick scheduler.
package tick_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CLK_DIV = 100_000_000;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_PER_W   = 16;

  // Bits needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the channel-select field for n channels.
  function automatic int ch_width(input int n);
    return clog2_min1(n);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..CLK_DIV-1 while run is high and flags the wrap cycle.
// Held at 0 whenever run is low, so every run starts from a fresh phase.
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic wrap
);

  localparam int            PW   = clog2_min1(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt;

  // Combinational so the top can register base_tick and channel ticks on the same edge.
  assign wrap = run && (cnt == LAST);

  // Prescale counter: cleared when idle or on wrap, otherwise increments.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (!run || wrap) begin
      cnt <= '0;
    end else begin
      // NOTE: non-blocking (<=) for every flop so all registers update from pre-edge values.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: one shared prescaler producing a base tick every CLK_DIV cycles, fanned out
// to NUM_CH channels that each pulse once every <period> base ticks. start/stop controlled.
// Optional feature: define TICK_SCHED_ONESHOT_EN to add input cfg_oneshot; a oneshot channel
// clears its enable after its first tick.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int CLK_DIV = DEF_CLK_DIV,
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int PER_W   = DEF_PER_W,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic              cfg_en,
`ifdef TICK_SCHED_ONESHOT_EN
  input  logic              cfg_oneshot,
`endif
  output logic              base_tick,
  output logic [NUM_CH-1:0] ch_tick,
  output logic              busy,
  output logic              cfg_err
);

  state_t state;
  logic   run;
  logic   wrap;
  logic   stop_evt;
  logic   ch_ok;

  // A stop sampled in RUN clears the prescaler on that same edge.
  assign stop_evt = (state == RUN) && stop;
  assign run      = (state == RUN) && !stop;
  assign busy     = (state == RUN);

  // Channel index range check only exists when NUM_CH leaves unused codes.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_partial
    assign ch_ok = (cfg_ch < CH_W'(NUM_CH));
  end

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .clr  (clr),
    .run  (run),
    .wrap (wrap)
  );

  // Run/idle FSM plus registered base_tick and cfg_err pulses; stop wins over start.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      base_tick <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      base_tick <= wrap;
      cfg_err   <= cfg_we && !ch_ok;
      case (state)
        IDLE:    if (start && !stop) state <= RUN;
        RUN:     if (stop)           state <= IDLE;
        default:                     state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] cnt;
    logic             en;
    logic             tick_q;
    logic             hit;
`ifdef TICK_SCHED_ONESHOT_EN
    logic             oneshot;
`endif

    assign hit        = cfg_we && (cfg_ch == CH_W'(i));
    assign ch_tick[i] = tick_q;

    // Channel countdown: a config write beats a stop reload, which beats a base-tick count.
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        // NOTE: config registers are reset on purpose; a reset must not leave stale channel setup.
        period <= '0;
        cnt    <= '0;
        en     <= 1'b0;
        tick_q <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot <= 1'b0;
`endif
      end else begin
        tick_q <= 1'b0;
        if (hit) begin
          period <= cfg_period;
          en     <= cfg_en;
          cnt    <= cfg_period;
`ifdef TICK_SCHED_ONESHOT_EN
          oneshot <= cfg_oneshot;
`endif
        end else if (stop_evt) begin
          cnt <= period;
        end else if (wrap && en && (period != '0)) begin
          if (cnt <= PER_W'(1)) begin
            tick_q <= 1'b1;
            cnt    <= period;
`ifdef TICK_SCHED_ONESHOT_EN
            if (oneshot) en <= 1'b0;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed literal checks plus randomized run against a behavioural model.
// Two DUTs share the stimulus: NUM_CH=4 (main) and NUM_CH=3 (exercises out-of-range writes).
module tb_tick_scheduler;

  localparam int CLK_DIV = 4;
  localparam int PER_W   = 8;

  logic             clk = 1'b0;
  logic             clr;
  logic             start, stop, cfg_we, cfg_en;
  logic [1:0]       cfg_ch;
  logic [PER_W-1:0] cfg_period;
`ifdef TICK_SCHED_ONESHOT_EN
  logic             cfg_oneshot;
`endif

  logic       base4, busy4, err4;
  logic [3:0] tick4;
  logic       base3, busy3, err3;
  logic [2:0] tick3;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  cmp_on   = 1'b0;

  always #5 clk = ~clk;

  tick_scheduler #(.CLK_DIV(CLK_DIV), .NUM_CH(4), .PER_W(PER_W)) dut4 (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .stop       (stop),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
`ifdef TICK_SCHED_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .base_tick  (base4),
    .ch_tick    (tick4),
    .busy       (busy4),
    .cfg_err    (err4)
  );

  tick_scheduler #(.CLK_DIV(CLK_DIV), .NUM_CH(3), .PER_W(PER_W)) dut3 (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .stop       (stop),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
`ifdef TICK_SCHED_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .base_tick  (base3),
    .ch_tick    (tick3),
    .busy       (busy3),
    .cfg_err    (err3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Base tick: every CLK_DIV-th edge counted since the start edge.
  // Channel: counts base ticks since its last write/stop; fires when that count is a multiple of period.
  int       m_per  [2][4];
  bit       m_en   [2][4];
  bit       m_os   [2][4];
  int       m_k    [2][4];
  bit       m_run  [2];
  int       m_runc [2];
  bit       m_base [2];
  bit [3:0] m_tick [2];
  bit       m_err  [2];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 1'b0; m_runc[d] = 0; m_base[d] = 1'b0; m_tick[d] = '0; m_err[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_per[d][c] = 0; m_en[d][c] = 1'b0; m_os[d][c] = 1'b0; m_k[d][c] = 0;
      end
    end
  endtask

  task automatic model_step(input int d);
    bit wr_ok;
    bit base_edge;
    wr_ok     = cfg_we && (int'(cfg_ch) < nch(d));
    base_edge = 1'b0;
    m_base[d] = 1'b0;
    m_tick[d] = '0;
    m_err[d]  = cfg_we && !wr_ok;
    if (m_run[d]) begin
      if (stop) begin
        m_run[d] = 1'b0;
        for (int c = 0; c < 4; c++) m_k[d][c] = 0;
      end else begin
        m_runc[d]++;
        if (m_runc[d] % CLK_DIV == 0) base_edge = 1'b1;
      end
    end else if (start && !stop) begin
      m_run[d]  = 1'b1;
      m_runc[d] = 0;
    end
    m_base[d] = base_edge;
    for (int c = 0; c < nch(d); c++) begin
      if (wr_ok && int'(cfg_ch) == c) begin
        m_per[d][c] = int'(cfg_period);
        m_en[d][c]  = cfg_en;
        m_k[d][c]   = 0;
`ifdef TICK_SCHED_ONESHOT_EN
        m_os[d][c]  = cfg_oneshot;
`endif
      end else if (base_edge && m_en[d][c] && m_per[d][c] != 0) begin
        m_k[d][c]++;
        if (m_k[d][c] % m_per[d][c] == 0) begin
          m_tick[d][c] = 1'b1;
          if (m_os[d][c]) m_en[d][c] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge clr) begin
    if (!clr) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("m4_base", base4, m_base[0]);
      check("m4_tick", tick4, m_tick[0]);
      check("m4_busy", busy4, m_run[0]);
      check("m4_err",  err4,  m_err[0]);
      check("m3_base", base3, m_base[1]);
      check("m3_tick", tick3, m_tick[1][2:0]);
      check("m3_busy", busy3, m_run[1]);
      check("m3_err",  err3,  m_err[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int per, input bit en, input bit os);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = PER_W'(per);
    cfg_en     = en;
`ifdef TICK_SCHED_ONESHOT_EN
    cfg_oneshot = os;
`else
    if (os) $display("note: oneshot request ignored in this build");
`endif
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_en = 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
    cfg_oneshot = 1'b0;
`endif
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    check("rst_base", base4, 0);
    check("rst_tick", tick4, 0);
    check("rst_busy", busy4, 0);
    check("rst_err3", err3, 0);
    #2 clr = 1'b1;
    @(negedge clk);

    // ch0 p=1, ch1 p=3, ch2 p=0 en, ch3 p=5 disabled
    cfg_write(0, 1, 1'b1, 1'b0);
    cfg_write(1, 3, 1'b1, 1'b0);
    cfg_write(2, 0, 1'b1, 1'b0);
    cfg_write(3, 5, 1'b0, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;          // edge 0
    check("start_busy", busy4, 1);
    for (int n = 1; n <= 51; n++) begin
      if (n == 36) begin                          // rewrite ch1 p=2 on a ch1 firing edge
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd2; cfg_en = 1'b1;
      end
      cyc();
      cfg_we = 1'b0;
      check("dir_base", base4, (n % 4 == 0));
      check("dir_ch0", tick4[0], (n % 4 == 0));
      check("dir_ch1", tick4[1], (n < 36) ? (n % 12 == 0) : (n == 44));
      check("dir_ch23", tick4[3:2], 0);
    end

    // stop on a base-tick edge: no pulses, busy drops
    stop = 1'b1; cyc(); stop = 1'b0;            // edge 52
    check("stop_base", base4, 0);
    check("stop_tick", tick4, 0);
    check("stop_busy", busy4, 0);
    for (int n = 0; n < 8; n++) begin
      cyc();
      check("idle_pulse", {base4, tick4}, 0);
    end
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("ss_idle_busy", busy4, 0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      cyc();
      check("re_base", base4, (m % 4 == 0));
      check("re_ch0", tick4[0], (m % 4 == 0));
      check("re_ch1", tick4[1], (m == 8));
    end

    // asynchronous reset mid-run
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    check("arst_base", base4, 0);
    check("arst_tick", tick4, 0);
    check("arst_busy", busy4, 0);
    @(negedge clk);
    #2 clr = 1'b1;
    @(negedge clk);
    start = 1'b1; cyc(); start = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      cyc();
      check("post_rst_tick", tick4, 0);
      check("post_rst_base", base4, (m % 4 == 0));
    end

`ifdef TICK_SCHED_ONESHOT_EN
    stop = 1'b1; cyc(); stop = 1'b0;
    cfg_write(0, 2, 1'b1, 1'b1);
    cfg_oneshot = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      cyc();
      check("oneshot_ch0", tick4[0], (n == 8));
    end
`endif

    // out-of-range channel on the 3-channel instance
    cfg_write(3, 5, 1'b1, 1'b0);
    check("err3_pulse", err3, 1);
    check("err4_quiet", err4, 0);
    cyc();
    check("err3_clear", err3, 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      stop       = ($urandom_range(0, 63) == 0);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = PER_W'($urandom_range(0, 6));
      cfg_en     = ($urandom_range(0, 4) != 0);
`ifdef TICK_SCHED_ONESHOT_EN
      cfg_oneshot = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        #2 clr = 1'b0;
        @(negedge clk);
        #2 clr = 1'b1;
      end
      @(negedge clk);
    end

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
